// File: rtl/cdc_tx_arbiter_if.sv
// Handshake bundle between local requesters, the arbiter and the CDC sender.
// master: arbiter side; slave: requesters plus sender side.
interface cdc_tx_arbiter_if #(
  parameter int NREQ      = 4,
  parameter int DATA_BITS = 8,
  parameter int OWN_BITS  = 2
);
  logic [NREQ-1:0]           req;
  logic [NREQ*DATA_BITS-1:0] req_data;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           done;
  logic                      send;
  logic [DATA_BITS-1:0]      data_in;
  logic                      busy;
  logic                      active;
  logic [OWN_BITS-1:0]       owner;

  modport master (
    input  req, req_data, busy,
    output gnt, done, send, data_in, active, owner
  );

  modport slave (
    output req, req_data, busy,
    input  gnt, done, send, data_in, active, owner
  );
endinterface

// File: rtl/cdc_tx_arbiter.sv
// Arbiter sharing one four-phase CDC sender among NREQ requesters.
// CDC_TX_ARB_ROUND_ROBIN_EN selects round-robin; undefined gives fixed lowest-index priority.
//
// state     | meaning
// IDLE      | waiting for a request while the channel is quiet
// ISSUE     | send and gnt pulse for the selected owner
// WAIT_RISE | waiting for the sender to report busy
// WAIT_FALL | waiting for the four-phase handshake to finish
// DONE      | done pulse for the owner
module cdc_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int DATA_BITS = 8,
  parameter int OWN_BITS  = 2
) (
  input  logic             clk,
  input  logic             rst,
  cdc_tx_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RISE,
    S_WAIT_FALL,
    S_DONE
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic                 load;
  logic                 win_vld;
  logic [OWN_BITS-1:0]  win_idx;
  logic [DATA_BITS-1:0] win_data;
  logic [DATA_BITS-1:0] data_q;
  logic [OWN_BITS-1:0]  owner_q;

`ifdef CDC_TX_ARB_ROUND_ROBIN_EN
  logic [OWN_BITS-1:0] last_q;
  int                  dist;
  int                  best;

  // Smallest forward distance from last_q+1 (with wrap) wins.
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    best     = NREQ;
    dist     = 0;
    for (int i = 0; i < NREQ; i++) begin
      dist = i - int'(last_q) - 1;
      if (dist < 0) dist = dist + NREQ;
      if (bus.req[i] && (dist < best)) begin
        best     = dist;
        win_vld  = 1'b1;
        win_idx  = OWN_BITS'(i);
        win_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end
`else
  always_comb begin
    win_vld  = 1'b0;
    win_idx  = '0;
    win_data = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (bus.req[i]) begin
        win_vld  = 1'b1;
        win_idx  = OWN_BITS'(i);
        win_data = bus.req_data[i*DATA_BITS +: DATA_BITS];
      end
    end
  end
`endif

  // A busy channel in IDLE belongs to someone else; never start on top of it.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      S_IDLE: begin
        if (!bus.busy && win_vld) begin
          load      = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE:     state_nxt = S_WAIT_RISE;
      S_WAIT_RISE: if (bus.busy) state_nxt = S_WAIT_FALL;
      S_WAIT_FALL: if (!bus.busy) state_nxt = S_DONE;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      data_q  <= '0;
      owner_q <= '0;
`ifdef CDC_TX_ARB_ROUND_ROBIN_EN
      last_q  <= OWN_BITS'(NREQ - 1);
`endif
    end else begin
      state <= state_nxt;
      if (load) begin
        data_q  <= win_data;
        owner_q <= win_idx;
`ifdef CDC_TX_ARB_ROUND_ROBIN_EN
        last_q  <= win_idx;
`endif
      end
    end
  end

  // Outputs decode straight from the state register so reset clears them at once.
  assign bus.send    = (state == S_ISSUE);
  assign bus.gnt     = (state == S_ISSUE) ? (NREQ'(1) << owner_q) : '0;
  assign bus.done    = (state == S_DONE) ? (NREQ'(1) << owner_q) : '0;
  assign bus.active  = (state != S_IDLE);
  assign bus.data_in = data_q;
  assign bus.owner   = owner_q;

endmodule

// File: tb/tb_cdc_tx_arbiter.sv
// Scoreboard bench for cdc_tx_arbiter with a behavioural sender busy model.
// Arbitration expectations follow CDC_TX_ARB_ROUND_ROBIN_EN when defined.
module tb_cdc_tx_arbiter;
  localparam int NREQ     = 4;
  localparam int DB       = 8;
  localparam int OB       = 2;
  localparam int BUSY_LEN = 5;

  typedef struct {
    int         idx;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdc_tx_arbiter_if #(.NREQ(NREQ), .DATA_BITS(DB), .OWN_BITS(OB)) bus ();

  cdc_tx_arbiter #(.NREQ(NREQ), .DATA_BITS(DB), .OWN_BITS(OB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic force_busy = 1'b0;
  logic model_busy = 1'b0;
  logic pend       = 1'b0;
  int   hold       = 0;
  assign bus.busy = model_busy | force_busy;

  exp_t       q[$];
  int         n_vec    = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         done_cnt = 0;
  bit         in_xfer  = 1'b0;
  int         own_exp  = 0;
  int         gnt_cyc  = 0;
  logic [7:0] data_exp = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int idx, input logic [7:0] d);
    exp_t e;
    e.idx  = idx;
    e.data = d;
    q.push_back(e);
  endtask

  // Sender model: send seen in cycle T raises busy in T+2 for BUSY_LEN cycles.
  always @(negedge clk) if (!rst && bus.send) pend = 1'b1;
  always begin
    @(posedge clk);
    #1;
    if (rst) begin
      model_busy = 1'b0;
      hold       = 0;
      pend       = 1'b0;
    end else if (pend) begin
      model_busy = 1'b1;
      hold       = BUSY_LEN;
      pend       = 1'b0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) model_busy = 1'b0;
    end
  end

  always @(negedge clk) begin : mon
    exp_t e;
    cyc++;
    if (!rst) begin
      if (bus.gnt != '0 || bus.send) begin
        if (q.size() == 0) begin
          check("unexpected_grant", 32'({bus.send, bus.gnt}), 32'h0);
        end else begin
          e = q.pop_front();
          check("gnt", 32'(bus.gnt), 32'(1 << e.idx));
          check("send_with_gnt", 32'(bus.send), 32'h1);
          check("data_in", 32'(bus.data_in), 32'(e.data));
          check("owner", 32'(bus.owner), 32'(e.idx));
          check("send_while_busy", 32'(bus.busy), 32'h0);
          check("grant_overlap", 32'(in_xfer), 32'h0);
          in_xfer  = 1'b1;
          own_exp  = e.idx;
          data_exp = e.data;
          gnt_cyc  = cyc;
        end
      end
      check("active", 32'(bus.active), 32'(in_xfer));
      if (bus.done != '0) begin
        check("done", 32'(bus.done), in_xfer ? 32'(1 << own_exp) : 32'h0);
        check("done_gap", 32'((cyc - gnt_cyc) >= 3), 32'h1);
        check("data_held", 32'(bus.data_in), 32'(data_exp));
        in_xfer = 1'b0;
        done_cnt++;
      end
    end
  end

  task automatic wait_q_empty(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("grant_timeout", 32'(q.size()), 32'h0);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'h1);
  endtask

  task automatic wait_busy(input int budget);
    int n = 0;
    while (!bus.busy && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("busy_timeout", 32'(bus.busy), 32'h1);
  endtask

  task automatic clear_model();
    q.delete();
    in_xfer    = 1'b0;
    model_busy = 1'b0;
    pend       = 1'b0;
    hold       = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_send"}, 32'(bus.send), 32'h0);
    check({tag, "_gnt"}, 32'(bus.gnt), 32'h0);
    check({tag, "_done"}, 32'(bus.done), 32'h0);
    check({tag, "_active"}, 32'(bus.active), 32'h0);
    check({tag, "_data_in"}, 32'(bus.data_in), 32'h0);
    check({tag, "_owner"}, 32'(bus.owner), 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d;
    bus.req      = '0;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'hA5};
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Single request from requester 0
    d = done_cnt;
    push(0, 8'hA5);
    bus.req = 4'b0001;
    @(negedge clk);
    #1;
    check("single_latency_gnt", 32'(bus.gnt), 32'h1);
    check("single_latency_data", 32'(bus.data_in), 32'hA5);
    bus.req = '0;
    wait_done(d + 1, 40);

    // Contention with all requests held
    do_reset();
    d = done_cnt;
`ifdef CDC_TX_ARB_ROUND_ROBIN_EN
    push(0, 8'hA5); push(1, 8'h22); push(2, 8'h33); push(3, 8'h44); push(0, 8'hA5);
    bus.req = 4'b1111;
    wait_q_empty(200);
    bus.req = '0;
    wait_done(d + 5, 40);
`else
    push(1, 8'h22); push(1, 8'h22); push(1, 8'h22); push(1, 8'h22);
    bus.req = 4'b0110;
    wait_q_empty(200);
    bus.req = '0;
    wait_done(d + 4, 40);
`endif

    // Channel already busy: nothing may be issued until it clears
    d = done_cnt;
    force_busy = 1'b1;
    bus.req    = 4'b0100;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("prebusy_no_send", 32'({bus.send, bus.gnt}), 32'h0);
    end
    push(2, 8'h33);
    @(posedge clk);
    #1;
    force_busy = 1'b0;
    @(negedge clk);
    #1;
    check("prebusy_gnt_early", 32'(bus.gnt), 32'h0);
    @(negedge clk);
    #1;
    check("prebusy_gnt", 32'(bus.gnt), 32'h4);
    bus.req = '0;
    wait_done(d + 1, 40);

    // Request withdrawn while the arbiter sits in WAIT_FALL
    d = done_cnt;
    push(0, 8'hA5);
    bus.req = 4'b0001;
    wait_q_empty(10);
    bus.req = '0;
    wait_busy(10);
    @(negedge clk);
    #1;
    bus.req = 4'b1000;
    @(negedge clk);
    #1;
    bus.req = '0;
    wait_done(d + 1, 40);
    repeat (8) @(negedge clk);
    #1;
    check("withdrawn_idle", 32'(bus.active), 32'h0);
    check("withdrawn_no_grant", 32'(q.size()), 32'h0);

    // Reset while waiting for busy to fall
    push(1, 8'h22);
    bus.req = 4'b0010;
    wait_q_empty(10);
    bus.req = '0;
    wait_busy(10);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    clear_model();
    @(negedge clk);
    #1;
    rst = 1'b0;
    d = done_cnt;
    push(3, 8'h44);
    bus.req = 4'b1000;
    wait_q_empty(10);
    bus.req = '0;
    wait_done(d + 1, 40);
    push(0, 8'hA5);
    bus.req = 4'b0011;
    wait_q_empty(20);
    bus.req = '0;
    wait_done(d + 2, 40);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
